// File: rtl/mme_control.sv
// Montgomery modular exponentiation controller.
// Walks the exponent MSB-first (left-to-right square-and-multiply) and drives
// an external Montgomery multiplier (mmm) one operation at a time. The result
// is converted out of Montgomery form by a final multiply with 1.
module mme_control #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rn,
  input  logic         start,
  input  logic [N-1:0] x_bar,
  input  logic [N-1:0] r_mod,
  input  logic [N-1:0] e,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] y,
  output logic         mmm_start,
  output logic [N-1:0] mmm_a,
  output logic [N-1:0] mmm_b,
  input  logic         mmm_ready,
  input  logic [N-1:0] mmm_y
);

  localparam int            IW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] I_TOP = IW'(N - 1);
  localparam logic [N-1:0]  ONE   = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    SQ_GO,
    SQ_WAIT,
    MUL_GO,
    MUL_WAIT,
    OUT_GO,
    OUT_WAIT,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [N-1:0]  x_bar_lat;
  logic [N-1:0]  e_lat;
  logic [N-1:0]  acc;
  logic [IW-1:0] i;
  logic [N-1:0]  y_r;

  // High in the first cycle after mmm_start, when mmm_ready may still show
  // the previous operation's stale "ready" and must not be trusted.
  logic          fresh_p0;
  logic          op_done;

  logic          accept;
  logic          acc_ld;
  logic          i_dec;
  logic          y_ld;

  assign op_done = mmm_ready & ~fresh_p0;
  assign y       = y_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rn) state <= IDLE;
    else    state <= state_nxt;
  end

  // Next-state decode, mmm handshake and operand selection.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    mmm_start = 1'b0;
    mmm_a     = '0;
    mmm_b     = '0;
    accept    = 1'b0;
    acc_ld    = 1'b0;
    i_dec     = 1'b0;
    y_ld      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          accept    = 1'b1;
          state_nxt = SQ_GO;
        end
      end
      SQ_GO: begin
        mmm_start = 1'b1;
        mmm_a     = acc;
        mmm_b     = acc;
        state_nxt = SQ_WAIT;
      end
      SQ_WAIT: begin
        mmm_a = acc;
        mmm_b = acc;
        if (op_done) begin
          acc_ld = 1'b1;
          if (e_lat[i]) begin
            state_nxt = MUL_GO;
          end else if (i == '0) begin
            state_nxt = OUT_GO;
          end else begin
            i_dec     = 1'b1;
            state_nxt = SQ_GO;
          end
        end
      end
      MUL_GO: begin
        mmm_start = 1'b1;
        mmm_a     = acc;
        mmm_b     = x_bar_lat;
        state_nxt = MUL_WAIT;
      end
      MUL_WAIT: begin
        mmm_a = acc;
        mmm_b = x_bar_lat;
        if (op_done) begin
          acc_ld = 1'b1;
          if (i == '0) begin
            state_nxt = OUT_GO;
          end else begin
            i_dec     = 1'b1;
            state_nxt = SQ_GO;
          end
        end
      end
      OUT_GO: begin
        mmm_start = 1'b1;
        mmm_a     = acc;
        mmm_b     = ONE;
        state_nxt = OUT_WAIT;
      end
      OUT_WAIT: begin
        mmm_a = acc;
        mmm_b = ONE;
        if (op_done) begin
          y_ld      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand latches, accumulator, bit index and result register.
  always_ff @(posedge clk) begin
    if (rn) begin
      fresh_p0  <= 1'b0;
      x_bar_lat <= '0;
      e_lat     <= '0;
      acc       <= '0;
      i         <= '0;
      y_r       <= '0;
    end else begin
      fresh_p0 <= mmm_start;
      if (accept) begin
        x_bar_lat <= x_bar;
        e_lat     <= e;
        acc       <= r_mod;
        i         <= I_TOP;
      end
      if (acc_ld) acc <= mmm_y;
      if (i_dec)  i   <= i - 1'b1;
      if (y_ld)   y_r <= mmm_y;
    end
  end

endmodule
